mutex_grant_gen: RTL and testbench

Two-requester mutual-exclusion grant generator: the producing end of the `!(a && b)` exclusivity contract that the team's immediate-assertion checkers monitor. It arbitrates `req_a`/`req_b` round-robin and drives `grant_a`/`grant_b` so they are never high together. It enforces a guaranteed dead gap between owners and a bounded hold time, and keeps coverage counters for grants and forced revocations. It sits between two clients of a shared resource, and its grant outputs feed exclusivity checkers directly.

---
 rtl/mutex_grant_gen.sv | 149 ++++++++++++++
 tb/tb_mutex_grant_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mutex_grant_gen.sv
//------------------------------------------------------------------------------
// mutex_grant_gen : round-robin two-client mutex with dead gap, hold limit
//                   and saturating grant/timeout statistics.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mutex_grant_gen #(
  parameter int MAX_HOLD   = 8,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  output logic             grant_a,
  output logic             grant_b,
  output logic             busy,
  output logic             timeout_pulse,
  output logic [CNT_W-1:0] grant_cnt_a,
  output logic [CNT_W-1:0] grant_cnt_b,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);
  localparam logic [3:0] c_gap      = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  state_t             w_pick;
  logic               r_last_b;      // last owner: 1 = B, 0 = A
  logic [7:0]         r_hold_cnt;
  logic [3:0]         r_gap_cnt;
  logic               r_grant_a;
  logic               r_grant_b;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_cnt_a;
  logic [CNT_W-1:0]   r_cnt_b;
  logic [CNT_W-1:0]   r_cnt_to;
  logic               w_revoke;
  logic               w_enter_a;
  logic               w_enter_b;

  // Arbitration shared by IDLE and gap expiry; ties go to the non-last owner.
  always_comb begin
    w_pick = IDLE;
    if (req_a && req_b) begin
      w_pick = r_last_b ? OWN_A : OWN_B;
    end else if (req_a) begin
      w_pick = OWN_A;
    end else if (req_b) begin
      w_pick = OWN_B;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_revoke = 1'b0;
    case (r_state)
      IDLE: w_next = w_pick;
      OWN_A: begin
        if (!req_a) begin
          w_next = GAP;
        end else if (r_hold_cnt == c_max_hold) begin
          w_next   = GAP;
          w_revoke = 1'b1;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          w_next = GAP;
        end else if (r_hold_cnt == c_max_hold) begin
          w_next   = GAP;
          w_revoke = 1'b1;
        end
      end
      GAP: begin
        if (r_gap_cnt == c_gap) begin
          w_next = w_pick;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_enter_a = (w_next == OWN_A) && (r_state != OWN_A);
  assign w_enter_b = (w_next == OWN_B) && (r_state != OWN_B);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last_b   <= 1'b1;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_grant_a  <= 1'b0;
      r_grant_b  <= 1'b0;
      r_timeout  <= 1'b0;
      r_cnt_a    <= '0;
      r_cnt_b    <= '0;
      r_cnt_to   <= '0;
    end else begin
      r_state   <= w_next;
      r_grant_a <= (w_next == OWN_A);
      r_grant_b <= (w_next == OWN_B);
      r_timeout <= w_revoke;

      if (w_enter_a) begin
        r_last_b   <= 1'b0;
        r_hold_cnt <= 8'd1;
        if (r_cnt_a != '1) r_cnt_a <= r_cnt_a + 1'b1;
      end else if (w_enter_b) begin
        r_last_b   <= 1'b1;
        r_hold_cnt <= 8'd1;
        if (r_cnt_b != '1) r_cnt_b <= r_cnt_b + 1'b1;
      end else if (w_next == r_state && (r_state == OWN_A || r_state == OWN_B)) begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end

      if (w_next == GAP) begin
        r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 4'd1 : 4'd1;
      end else begin
        r_gap_cnt <= '0;
      end

      if (w_revoke && r_cnt_to != '1) begin
        r_cnt_to <= r_cnt_to + 1'b1;
      end
    end
  end

  assign grant_a       = r_grant_a;
  assign grant_b       = r_grant_b;
  assign busy          = (r_state != IDLE);
  assign timeout_pulse = r_timeout;
  assign grant_cnt_a   = r_cnt_a;
  assign grant_cnt_b   = r_cnt_b;
  assign timeout_cnt   = r_cnt_to;

endmodule

`default_nettype wire

// File: tb/tb_mutex_grant_gen.sv
//------------------------------------------------------------------------------
// tb_mutex_grant_gen : directed scoreboard bench over three parameterisations.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mutex_grant_gen;

  logic clk;
  logic rst_n;

  // u0: defaults (8,1,16); u1: MAX_HOLD=4, GAP_CYCLES=2; u2: CNT_W=2
  logic ra0, rb0, ga0, gb0, bz0, tp0;
  logic ra1, rb1, ga1, gb1, bz1, tp1;
  logic ra2, rb2, ga2, gb2, bz2, tp2;
  logic [15:0] ca0, cb0, tc0, ca1, cb1, tc1;
  logic [1:0]  ca2, cb2, tc2;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int    inst;
    string tag;
    logic  ga;
    logic  gb;
    logic  bz;
    logic  tp;
  } exp_t;

  typedef struct {
    int          inst;
    string       tag;
    logic [15:0] ca;
    logic [15:0] cb;
    logic [15:0] tc;
  } cexp_t;

  exp_t  sb[$];
  cexp_t csb[$];

  mutex_grant_gen u0 (
    .clk(clk), .rst_n(rst_n), .req_a(ra0), .req_b(rb0),
    .grant_a(ga0), .grant_b(gb0), .busy(bz0), .timeout_pulse(tp0),
    .grant_cnt_a(ca0), .grant_cnt_b(cb0), .timeout_cnt(tc0)
  );

  mutex_grant_gen #(.MAX_HOLD(4), .GAP_CYCLES(2), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .req_a(ra1), .req_b(rb1),
    .grant_a(ga1), .grant_b(gb1), .busy(bz1), .timeout_pulse(tp1),
    .grant_cnt_a(ca1), .grant_cnt_b(cb1), .timeout_cnt(tc1)
  );

  mutex_grant_gen #(.MAX_HOLD(8), .GAP_CYCLES(1), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req_a(ra2), .req_b(rb2),
    .grant_a(ga2), .grant_b(gb2), .busy(bz2), .timeout_pulse(tp2),
    .grant_cnt_a(ca2), .grant_cnt_b(cb2), .timeout_cnt(tc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, string field, logic [15:0] obs, logic [15:0] ex);
    n_checks++;
    assert (obs === ex) n_pass++;
    else $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, ex);
  endtask

  // Exclusivity on every cycle of every instance.
  always @(negedge clk) begin
    chk("mutex_u0", "a&b", {15'd0, ga0 & gb0 & 1'b1} & {15'd0, (ga0 & gb0) === 1'b1}, 16'd0);
    chk("mutex_u1", "a&b", {15'd0, (ga1 & gb1) === 1'b1}, 16'd0);
    chk("mutex_u2", "a&b", {15'd0, (ga2 & gb2) === 1'b1}, 16'd0);
  end

  task automatic drive(int inst, logic ra, logic rb);
    case (inst)
      0: begin ra0 = ra; rb0 = rb; end
      1: begin ra1 = ra; rb1 = rb; end
      default: begin ra2 = ra; rb2 = rb; end
    endcase
  endtask

  task automatic read_out(int inst, output logic ga, output logic gb,
                          output logic bz, output logic tp);
    case (inst)
      0: begin ga = ga0; gb = gb0; bz = bz0; tp = tp0; end
      1: begin ga = ga1; gb = gb1; bz = bz1; tp = tp1; end
      default: begin ga = ga2; gb = gb2; bz = bz2; tp = tp2; end
    endcase
  endtask

  task automatic read_cnt(int inst, output logic [15:0] ca, output logic [15:0] cb,
                          output logic [15:0] tc);
    case (inst)
      0: begin ca = ca0; cb = cb0; tc = tc0; end
      1: begin ca = ca1; cb = cb1; tc = tc1; end
      default: begin ca = {14'd0, ca2}; cb = {14'd0, cb2}; tc = {14'd0, tc2}; end
    endcase
  endtask

  // Drive requests, queue the expected post-edge outputs, clock, then compare.
  task automatic step(int inst, logic ra, logic rb, string tag,
                      logic ega, logic egb, logic ebz, logic etp);
    exp_t e;
    logic ga, gb, bz, tp;
    drive(inst, ra, rb);
    e.inst = inst; e.tag = tag; e.ga = ega; e.gb = egb; e.bz = ebz; e.tp = etp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    read_out(e.inst, ga, gb, bz, tp);
    chk(e.tag, "grant_a", {15'd0, ga}, {15'd0, e.ga});
    chk(e.tag, "grant_b", {15'd0, gb}, {15'd0, e.gb});
    chk(e.tag, "busy", {15'd0, bz}, {15'd0, e.bz});
    chk(e.tag, "timeout_pulse", {15'd0, tp}, {15'd0, e.tp});
  endtask

  task automatic expect_cnt(int inst, string tag, logic [15:0] eca,
                            logic [15:0] ecb, logic [15:0] etc);
    cexp_t c;
    logic [15:0] ca, cb, tc;
    c.inst = inst; c.tag = tag; c.ca = eca; c.cb = ecb; c.tc = etc;
    csb.push_back(c);
    c = csb.pop_front();
    read_cnt(c.inst, ca, cb, tc);
    chk(c.tag, "grant_cnt_a", ca, c.ca);
    chk(c.tag, "grant_cnt_b", cb, c.cb);
    chk(c.tag, "timeout_cnt", tc, c.tc);
  endtask

  initial begin
    rst_n = 1'b0;
    ra0 = 0; rb0 = 0; ra1 = 0; rb1 = 0; ra2 = 0; rb2 = 0;
    @(posedge clk);
    #1;

    // Reset with both requests high, then tie and handover on u0.
    step(0, 1, 1, "rst0", 0, 0, 0, 0);
    step(0, 1, 1, "rst1", 0, 0, 0, 0);
    expect_cnt(0, "rst_u0", 0, 0, 0);
    expect_cnt(1, "rst_u1", 0, 0, 0);
    expect_cnt(2, "rst_u2", 0, 0, 0);
    rst_n = 1'b1;
    step(0, 1, 1, "tie_e0", 1, 0, 1, 0);
    step(0, 1, 1, "tie_e1", 1, 0, 1, 0);
    step(0, 1, 1, "tie_e2", 1, 0, 1, 0);
    step(0, 0, 1, "tie_e3", 0, 0, 1, 0);
    step(0, 0, 1, "tie_e4", 0, 1, 1, 0);
    expect_cnt(0, "tie", 1, 1, 0);
    step(0, 0, 1, "tie_e5", 0, 1, 1, 0);
    step(0, 0, 0, "rel_b", 0, 0, 1, 0);
    step(0, 0, 0, "idle1", 0, 0, 0, 0);

    // Forced revoke: A alone holds 8 cycles, 1-cycle gap with pulse, regrant.
    for (int k = 0; k < 8; k++) step(0, 1, 0, $sformatf("hold%0d", k), 1, 0, 1, 0);
    step(0, 1, 0, "revoke", 0, 0, 1, 1);
    expect_cnt(0, "revoke", 2, 1, 1);
    step(0, 1, 0, "regrant", 1, 0, 1, 0);
    expect_cnt(0, "regrant", 3, 1, 1);
    step(0, 0, 0, "rel_a", 0, 0, 1, 0);
    step(0, 0, 0, "idle2", 0, 0, 0, 0);

    // Reset while B owns with hold_cnt = 3.
    step(0, 0, 1, "ownb0", 0, 1, 1, 0);
    step(0, 0, 1, "ownb1", 0, 1, 1, 0);
    step(0, 0, 1, "ownb2", 0, 1, 1, 0);
    rst_n = 1'b0;
    step(0, 0, 1, "rst_mid", 0, 0, 0, 0);
    expect_cnt(0, "rst_mid", 0, 0, 0);
    step(0, 1, 1, "rst_hold", 0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 1, 1, "tie_post", 1, 0, 1, 0);
    step(0, 0, 0, "rel_post", 0, 0, 1, 0);
    step(0, 0, 0, "idle3", 0, 0, 0, 0);

    // Revoke fairness on u1: 4-cycle grants alternating, 2-cycle gaps.
    for (int k = 0; k < 18; k++) begin
      int  pos;
      bit  own_a;
      pos   = k % 6;
      own_a = ((k / 6) % 2) == 0;
      step(1, 1, 1, $sformatf("fair%0d", k),
           (pos < 4) && own_a, (pos < 4) && !own_a, 1'b1, pos == 4);
    end
    expect_cnt(1, "fair", 2, 1, 3);
    step(1, 0, 0, "fair_idle", 0, 0, 0, 0);

    // Saturation on u2 (2-bit counters).
    for (int p = 0; p < 5; p++) begin
      step(2, 1, 0, $sformatf("sat_pulse%0d", p), 1, 0, 1, 0);
      expect_cnt(2, $sformatf("sat%0d", p), (p < 3) ? 16'(p + 1) : 16'd3, 0, 0);
      step(2, 0, 0, "sat_rel", 0, 0, 1, 0);
      step(2, 0, 0, "sat_idle_a", 0, 0, 0, 0);
      step(2, 0, 0, "sat_idle_b", 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
